// File: rtl/dmem_io_bus_arbiter.sv
// dmem_io_bus_arbiter
//
// Shares the CPU-side memory bus between two requesters (m0 = CPU load/store
// path, m1 = vector load/store unit). Grants are round-robin; the winner's
// address picks Data_Memory or IO_MEM (IO_MEM when addr[31:12] == IO_BASE_HI).
// The arbiter holds cs plus rd/wr for ACC_CYC cycles, samples mem_rdata on the
// last strobe cycle of a read, then pulses the owner's ack for one cycle.
//
// Handshake: a requester raises reqN with wr/addr/wdata and holds all of them
// stable until it sees ackN (one cycle). ackN is the only completion signal;
// rdataN is valid while ackN = 1 and holds its value until the next read done
// for that requester. Request changes while busy are ignored, and dropping
// req mid-access does not cancel it.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-low reset
//   m0_req/wr/addr/wdata       CPU request in
//   m0_ack/rdata               CPU completion pulse and read data
//   m1_*                       same for the vector unit
//   madr, idp                  address / write data to both memories
//   mem_rdata                  shared read-data return
//   dm_cs/rd/wr, io_cs/rd/wr   per-memory chip select and strobes
//   busy                       1 while an access is in ACCESS or DONE
//   gnt                        owner of the current or last transaction
//   dbg_state                  FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Every output comes straight from a flop: the combinational block computes
// next values and the sequential block registers them.
module dmem_io_bus_arbiter #(
  parameter int unsigned  ACC_CYC    = 1,
  parameter logic [19:0]  IO_BASE_HI = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] madr,
  output logic [31:0] idp,
  input  logic [31:0] mem_rdata,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        io_cs,
  output logic        io_rd,
  output logic        io_wr,
  output logic        busy,
  output logic        gnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_io_q, is_io_d;

  logic        gnt_d, busy_d, m0_ack_d, m1_ack_d;
  logic [31:0] m0_rdata_d, m1_rdata_d, madr_d, idp_d;
  logic        dm_cs_d, dm_rd_d, dm_wr_d, io_cs_d, io_rd_d, io_wr_d;

  logic        pick;   // winner if a grant happens this cycle
  logic        drive;  // strobes asserted in the next cycle

  // On a tie the requester that did not win last time goes next.
  assign pick = (m0_req && m1_req) ? ~last_gnt_q : m1_req;

  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_io_d    = is_io_q;
    gnt_d      = gnt;
    busy_d     = busy;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
    drive      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (m0_req || m1_req) begin
          wr_d       = pick ? m1_wr    : m0_wr;
          addr_d     = pick ? m1_addr  : m0_addr;
          wdata_d    = pick ? m1_wdata : m0_wdata;
          is_io_d    = (addr_d[31:12] == IO_BASE_HI);
          gnt_d      = pick;
          last_gnt_d = pick;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          drive      = 1'b1;  // first strobe cycle follows the grant edge
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          drive = 1'b1;
        end else begin
          // Last strobe cycle: memory data is valid now.
          if (!wr_q) begin
            if (gnt) m1_rdata_d = mem_rdata;
            else     m0_rdata_d = mem_rdata;
          end
          m0_ack_d = ~gnt;
          m1_ack_d = gnt;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    madr_d  = drive ? addr_d : 32'd0;
    idp_d   = (drive && wr_d) ? wdata_d : 32'd0;
    dm_cs_d = drive && !is_io_d;
    dm_rd_d = drive && !is_io_d && !wr_d;
    dm_wr_d = drive && !is_io_d && wr_d;
    io_cs_d = drive && is_io_d;
    io_rd_d = drive && is_io_d && !wr_d;
    io_wr_d = drive && is_io_d && wr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_gnt_q <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      is_io_q    <= 1'b0;
      gnt        <= 1'b0;
      busy       <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= 32'd0;
      m1_rdata   <= 32'd0;
      madr       <= 32'd0;
      idp        <= 32'd0;
      dm_cs      <= 1'b0;
      dm_rd      <= 1'b0;
      dm_wr      <= 1'b0;
      io_cs      <= 1'b0;
      io_rd      <= 1'b0;
      io_wr      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_io_q    <= is_io_d;
      gnt        <= gnt_d;
      busy       <= busy_d;
      m0_ack     <= m0_ack_d;
      m1_ack     <= m1_ack_d;
      m0_rdata   <= m0_rdata_d;
      m1_rdata   <= m1_rdata_d;
      madr       <= madr_d;
      idp        <= idp_d;
      dm_cs      <= dm_cs_d;
      dm_rd      <= dm_rd_d;
      dm_wr      <= dm_wr_d;
      io_cs      <= io_cs_d;
      io_rd      <= io_rd_d;
      io_wr      <= io_wr_d;
    end
  end

endmodule

// File: tb/tb_dmem_io_bus_arbiter.sv
// Testbench for dmem_io_bus_arbiter. Two instances: u_dut1 (ACC_CYC = 1) runs
// the directed single-cycle scenarios and a long randomized run against a
// timeline model; u_dut3 (ACC_CYC = 3) covers the multi-cycle window, reset
// abort and req drop. Inputs change and outputs are sampled on the falling edge.
module tb_dmem_io_bus_arbiter;

  localparam int          A1    = 1;
  localparam int          A3    = 3;
  localparam logic [19:0] IO_HI = 20'hFFFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- u_dut1 signals ----------------
  logic        m0_req, m0_wr, m0_ack, m1_req, m1_wr, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] madr, idp, mem_rdata;
  logic        dm_cs, dm_rd, dm_wr, io_cs, io_rd, io_wr, busy, gnt;
  logic [1:0]  dbg_state;
  logic [5:0]  str1;
  assign str1 = {dm_cs, dm_rd, dm_wr, io_cs, io_rd, io_wr};

  // ---------------- u_dut3 signals ----------------
  logic        b_m0_req, b_m0_wr, b_m0_ack, b_m1_req, b_m1_wr, b_m1_ack;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic [31:0] b_madr, b_idp, b_mem_rdata;
  logic        b_dm_cs, b_dm_rd, b_dm_wr, b_io_cs, b_io_rd, b_io_wr, b_busy, b_gnt;
  logic [1:0]  b_dbg_state;
  logic [5:0]  str3;
  assign str3 = {b_dm_cs, b_dm_rd, b_dm_wr, b_io_cs, b_io_rd, b_io_wr};

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];  // {owner, rdata expected at ack}

  dmem_io_bus_arbiter #(.ACC_CYC(A1), .IO_BASE_HI(IO_HI)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .madr(madr), .idp(idp), .mem_rdata(mem_rdata),
    .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
    .busy(busy), .gnt(gnt), .dbg_state(dbg_state)
  );

  dmem_io_bus_arbiter #(.ACC_CYC(A3), .IO_BASE_HI(IO_HI)) u_dut3 (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_wr(b_m0_wr), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_wr(b_m1_wr), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .madr(b_madr), .idp(b_idp), .mem_rdata(b_mem_rdata),
    .dm_cs(b_dm_cs), .dm_rd(b_dm_rd), .dm_wr(b_dm_wr),
    .io_cs(b_io_cs), .io_rd(b_io_rd), .io_wr(b_io_wr),
    .busy(b_busy), .gnt(b_gnt), .dbg_state(b_dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    b_m0_req = 0; b_m0_wr = 0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 0; b_m1_wr = 0; b_m1_addr = '0; b_m1_wdata = '0;
    mem_rdata = '0; b_mem_rdata = '0;
  endtask

  // Leaves the bench at a falling edge with rst released and outputs in reset state.
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (str1 !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=%b", str1, 6'b0); end
    checks++; if ({m0_ack, m1_ack, busy} !== 3'b0) begin failures++; $display("FAIL reset_ack_busy got=%b exp=000", {m0_ack, m1_ack, busy}); end
    checks++; if ({madr, idp} !== 64'd0) begin failures++; $display("FAIL reset_madr_idp got=%h exp=0", {madr, idp}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
    checks++; if ({str3, b_busy, b_m0_ack, b_m1_ack} !== 9'd0) begin failures++; $display("FAIL reset_dut3 got=%b exp=0", {str3, b_busy, b_m0_ack, b_m1_ack}); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h0000_0010; m0_wdata = 32'h1234_5678;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (str1 !== 6'b110000) begin failures++; $display("FAIL rd_strobes got=%b exp=%b", str1, 6'b110000); end
    checks++; if (madr !== 32'h10 || idp !== 32'd0) begin failures++; $display("FAIL rd_bus got=%h/%h exp=10/0", madr, idp); end
    checks++; if ({busy, gnt, m0_ack} !== 3'b100) begin failures++; $display("FAIL rd_busy_gnt got=%b exp=100", {busy, gnt, m0_ack}); end
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack} !== 2'b10) begin failures++; $display("FAIL rd_ack got=%b exp=10", {m0_ack, m1_ack}); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", m0_rdata); end
    checks++; if (str1 !== 6'b0 || madr !== 32'd0) begin failures++; $display("FAIL rd_done_bus got=%b/%h exp=0/0", str1, madr); end
    m0_req = 0;
    @(negedge clk);
    checks++; if ({m0_ack, busy} !== 2'b00) begin failures++; $display("FAIL rd_after got=%b exp=00", {m0_ack, busy}); end
  endtask

  task automatic test_io_write();
    m1_req = 1; m1_wr = 1; m1_addr = 32'hFFFF_F004; m1_wdata = 32'h0000_00AA;
    mem_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if (str1 !== 6'b000101) begin failures++; $display("FAIL io_strobes got=%b exp=%b", str1, 6'b000101); end
    checks++; if (madr !== 32'hFFFF_F004 || idp !== 32'h0000_00AA) begin failures++; $display("FAIL io_bus got=%h/%h exp=fffff004/000000aa", madr, idp); end
    checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL io_gnt got=%b exp=1", gnt); end
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack} !== 2'b01) begin failures++; $display("FAIL io_ack got=%b exp=01", {m0_ack, m1_ack}); end
    checks++; if (m1_rdata !== 32'd0 || m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL io_rdata_keep got=%h/%h exp=0/deadbeef", m1_rdata, m0_rdata); end
    m1_req = 0;
    @(negedge clk);
    checks++; if ({m1_ack, busy, str1} !== 8'd0) begin failures++; $display("FAIL io_after got=%b exp=0", {m1_ack, busy, str1}); end
  endtask

  task automatic test_contention();
    int owners[$];
    int at[$];
    int n0 = 0;
    int n1 = 0;
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h0000_0100;
    m1_req = 1; m1_wr = 0; m1_addr = 32'hFFFF_F200;
    mem_rdata = 32'h0BAD_F00D;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) begin failures++; checks++; $display("FAIL cont_double_ack got=11 exp=one-hot"); end
      if (m0_ack) begin owners.push_back(0); at.push_back(k); n0++; if (n0 == 2) m0_req = 0; end
      if (m1_ack) begin owners.push_back(1); at.push_back(k); n1++; if (n1 == 2) m1_req = 0; end
    end
    checks++; if (owners.size() !== 4) begin failures++; $display("FAIL cont_count got=%0d exp=4", owners.size()); end
    for (int j = 0; j < 4 && j < owners.size(); j++) begin
      checks++; if (owners[j] !== (j % 2)) begin failures++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", j, owners[j], j % 2); end
      checks++; if (at[j] !== A1 + 1 + j * (A1 + 2)) begin failures++; $display("FAIL cont_time[%0d] got=%0d exp=%0d", j, at[j], A1 + 1 + j * (A1 + 2)); end
    end
  endtask

  task automatic test_acc_cyc3();
    int nrd = 0;
    int first_rd = 0;
    int nack = 0;
    int ack_k = 0;
    logic [31:0] ack_data = '0;
    int stray = 0;
    do_reset();
    b_m1_req = 1; b_m1_wr = 0; b_m1_addr = 32'h0000_0040;
    b_mem_rdata = 32'hA000_0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b_dm_cs && b_dm_rd) begin nrd++; if (first_rd == 0) first_rd = k; end
      if (b_io_cs || b_m0_ack || b_dm_wr) stray++;
      if (b_m1_ack) begin nack++; ack_k = k; ack_data = b_m1_rdata; b_m1_req = 0; end
      b_mem_rdata = 32'hA000_0000 + 32'(k);
    end
    checks++; if (nrd !== 3) begin failures++; $display("FAIL a3_rd_cycles got=%0d exp=3", nrd); end
    checks++; if (first_rd !== 1) begin failures++; $display("FAIL a3_first_rd got=%0d exp=1", first_rd); end
    checks++; if (nack !== 1 || ack_k !== 4) begin failures++; $display("FAIL a3_ack got=%0d@%0d exp=1@4", nack, ack_k); end
    checks++; if (ack_data !== 32'hA000_0003) begin failures++; $display("FAIL a3_data got=%h exp=a0000003", ack_data); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL a3_stray got=%0d exp=0", stray); end
  endtask

  task automatic test_reset_mid_access();
    int n0 = 0;
    int n1 = 0;
    bit m1_first = 0;
    do_reset();
    b_m0_req = 1; b_m0_wr = 1; b_m0_addr = 32'h0000_0080; b_m0_wdata = 32'h0000_0077;
    @(negedge clk);
    checks++; if (str3 !== 6'b101000 || b_idp !== 32'h77) begin failures++; $display("FAIL rst_wr_strobe got=%b/%h exp=101000/77", str3, b_idp); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++; if ({str3, b_busy, b_m0_ack, b_m1_ack} !== 9'd0) begin failures++; $display("FAIL rst_abort got=%b exp=0", {str3, b_busy, b_m0_ack, b_m1_ack}); end
    checks++; if ({b_madr, b_idp} !== 64'd0) begin failures++; $display("FAIL rst_abort_bus got=%h exp=0", {b_madr, b_idp}); end
    rst = 1;
    b_m0_wr = 0; b_m0_addr = 32'h0000_0084;
    b_m1_req = 1; b_m1_wr = 1; b_m1_addr = 32'h0000_0088; b_m1_wdata = 32'h99;
    @(negedge clk);
    checks++; if (b_gnt !== 1'b0 || str3 !== 6'b110000) begin failures++; $display("FAIL rst_tie got=%b/%b exp=0/110000", b_gnt, str3); end
    checks++; if (b_m0_ack !== 1'b0) begin failures++; $display("FAIL rst_no_ack got=%b exp=0", b_m0_ack); end
    for (int k = 0; k < 16; k++) begin
      if (b_m0_ack) begin n0++; b_m0_req = 0; end
      if (b_m1_ack) begin n1++; if (n0 == 0) m1_first = 1; b_m1_req = 0; end
      @(negedge clk);
    end
    checks++; if (n0 !== 1 || n1 !== 1 || m1_first !== 1'b0) begin failures++; $display("FAIL rst_after_acks got=%0d,%0d,%0d exp=1,1,0", n0, n1, m1_first); end
  endtask

  task automatic test_drop_req();
    int nrd = 0;
    int nack = 0;
    logic [31:0] ack_data = '0;
    do_reset();
    b_m0_req = 1; b_m0_wr = 0; b_m0_addr = 32'h0000_0200;
    b_mem_rdata = 32'h1111_2222;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (b_dm_cs && b_dm_rd) nrd++;
      if (b_m0_ack) begin nack++; ack_data = b_m0_rdata; end
      if (k == 1) b_m0_req = 0;
    end
    checks++; if (nrd !== 3) begin failures++; $display("FAIL drop_rd_cycles got=%0d exp=3", nrd); end
    checks++; if (nack !== 1) begin failures++; $display("FAIL drop_acks got=%0d exp=1", nack); end
    checks++; if (ack_data !== 32'h1111_2222) begin failures++; $display("FAIL drop_data got=%h exp=11112222", ack_data); end
    checks++; if ({b_busy, str3} !== 7'd0) begin failures++; $display("FAIL drop_idle got=%b exp=0", {b_busy, str3}); end
  endtask

  // Randomized run on u_dut1. The model is a timeline: a grant at edge g owns
  // the bus for edges g..g+A1-1 (strobes), acks after edge g+A1 and the bus is
  // idle again after edge g+A1+1; ties go to whoever did not win last.
  task automatic test_random();
    int e = 0;
    int g = 0;
    bit act = 0;
    bit own = 0;
    bit last = 1;
    bit gk = 0;
    bit lw = 0;
    bit lio = 0;
    logic [31:0] la = '0, lwd = '0;
    logic [31:0] erd [2];
    bit rq [2];
    bit rw [2];
    logic [31:0] ra [2];
    logic [31:0] rdv [2];
    logic [5:0] x_str;
    logic [31:0] x_madr, x_idp;
    logic [1:0] x_ack;
    logic x_busy;
    logic [32:0] sb;
    logic [32:0] got;
    bit fresh;
    bit ackd;
    do_reset();
    exp_q.delete();
    erd[0] = '0; erd[1] = '0;
    for (int i = 0; i < 2; i++) begin rq[i] = 0; rw[i] = 0; ra[i] = '0; rdv[i] = '0; end
    for (int c = 0; c < 2000; c++) begin
      x_str = '0; x_madr = '0; x_idp = '0; x_ack = '0; x_busy = 0;
      if (act) begin
        x_busy = 1;
        if (e - g < A1) begin
          x_str  = lio ? {3'b000, 1'b1, !lw, lw} : {1'b1, !lw, lw, 3'b000};
          x_madr = la;
          x_idp  = lw ? lwd : 32'd0;
        end else begin
          x_ack = own ? 2'b10 : 2'b01;  // {m1, m0}
        end
      end
      checks++; if (str1 !== x_str) begin failures++; $display("FAIL rnd_strobes c=%0d got=%b exp=%b", c, str1, x_str); end
      checks++; if (madr !== x_madr || idp !== x_idp) begin failures++; $display("FAIL rnd_bus c=%0d got=%h/%h exp=%h/%h", c, madr, idp, x_madr, x_idp); end
      checks++; if ({m1_ack, m0_ack} !== x_ack || busy !== x_busy) begin failures++; $display("FAIL rnd_ack_busy c=%0d got=%b/%b exp=%b/%b", c, {m1_ack, m0_ack}, busy, x_ack, x_busy); end
      checks++; if (m0_rdata !== erd[0] || m1_rdata !== erd[1]) begin failures++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, m0_rdata, m1_rdata, erd[0], erd[1]); end
      if (gk) begin
        checks++; if (gnt !== last) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, last); end
      end
      if (m0_ack || m1_ack) begin
        got = {m1_ack, m1_ack ? m1_rdata : m0_rdata};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_sb_spurious c=%0d got=%h exp=none", c, got);
        end else begin
          sb = exp_q.pop_front();
          if (got !== sb) begin failures++; $display("FAIL rnd_sb c=%0d got=%h exp=%h", c, got, sb); end
        end
      end
      // requesters: hold until own ack, then drop or present a new request
      for (int i = 0; i < 2; i++) begin
        ackd  = (i == 0) ? m0_ack : m1_ack;
        fresh = 0;
        if (rq[i]) begin
          if (ackd) begin
            rq[i] = (c < 1988) ? 1'($urandom_range(0, 1)) : 1'b0;
            fresh = rq[i];
          end
        end else if (c < 1988 && $urandom_range(0, 2) == 0) begin
          rq[i] = 1; fresh = 1;
        end
        if (fresh) begin
          rw[i]  = 1'($urandom_range(0, 1));
          ra[i]  = ($urandom_range(0, 1) == 1) ? {IO_HI, 12'($urandom())} : $urandom();
          rdv[i] = $urandom();
        end
      end
      m0_req = rq[0]; m0_wr = rw[0]; m0_addr = ra[0]; m0_wdata = rdv[0];
      m1_req = rq[1]; m1_wr = rw[1]; m1_addr = ra[1]; m1_wdata = rdv[1];
      mem_rdata = $urandom();
      // model step for the coming edge e+1
      if (act) begin
        if (e + 1 == g + A1) begin
          if (!lw) erd[own] = mem_rdata;
          exp_q.push_back({own, erd[own]});
        end else if (e + 1 == g + A1 + 1) begin
          act = 0;
        end
      end else if (rq[0] || rq[1]) begin
        own = (rq[0] && rq[1]) ? !last : rq[1];
        lw  = rw[own]; la = ra[own]; lwd = rdv[own];
        lio = (la[31:12] == IO_HI);
        g = e + 1; act = 1; last = own; gk = 1;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_sb_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_io_write();
    test_contention();
    test_acc_cyc3();
    test_reset_mid_access();
    test_drop_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_io_bus_arbiter.md
Name: dmem_io_bus_arbiter

Overview:
- Shares the CPU-side memory bus (madr, idp, dm_*/io_* strobes, read-data return) between two requesters: m0 = CPU load/store path, m1 = vector/SIMD load-store unit.
- Round-robin arbitration.
- Address decode selects Data_Memory or IO_MEM.
- Drives registered chip-select and read/write strobes for a fixed access window, captures read data, and returns a one-cycle ack.

Parameters:
- ACC_CYC, 1, number of cycles cs plus rd/wr are held asserted per access (1..15).
- IO_BASE_HI, 20'hFFFFF, addr[31:12] value that selects IO_MEM; any other value selects Data_Memory.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- m0_req  in  1  CPU request; held until m0_ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  32  CPU byte address
- m0_wdata  in  32  CPU write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid while m0_ack = 1
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_*, vector unit
- madr  out  32  memory address to both memories
- idp  out  32  write data to both memories
- mem_rdata  in  32  shared read-data return (mem_to_DY)
- dm_cs, dm_rd, dm_wr  out  1 each  Data_Memory controls
- io_cs, io_rd, io_wr  out  1 each  IO_MEM controls
- busy  out  1  1 while in ACCESS or DONE
- gnt  out  1  owner of the current or last transaction (0 = m0, 1 = m1)

Behaviour:
- All outputs are registered.
- Reset (rst = 0 at a rising edge):
  - state goes to IDLE.
  - All strobes, acks, busy, madr, idp, m0_rdata and m1_rdata go to 0.
  - last_gnt = 1, so m0 wins the first tie.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester that is not last_gnt.
  - On grant, latch wr, addr and wdata of the winner; set is_io = (addr[31:12] == IO_BASE_HI); set gnt and last_gnt; load cnt = ACC_CYC-1; go to ACCESS.
  - If no req is high, stay in IDLE with all strobes 0.
- ACCESS:
  - madr = latched addr.
  - idp = latched wdata on a write, 0 on a read.
  - Assert exactly one cs (dm_cs or io_cs, per is_io) together with the matching rd or wr. The other memory's signals stay at 0.
  - If cnt != 0, decrement cnt and stay.
  - If cnt == 0: for a read, capture mem_rdata into the owner's rdata register; go to DONE.
- DONE:
  - All strobes 0; madr = 0; idp = 0.
  - Owner's ack = 1 for exactly this cycle, and its rdata is valid.
  - On a write, rdata keeps its previous value.
  - Next state is IDLE.
- Latency: req sampled high at edge N gives strobes in cycles N+1..N+ACC_CYC and ack in cycle N+ACC_CYC+1. Back-to-back accesses cost ACC_CYC+2 cycles each.
- Requester rules:
  - A requester keeps req and its operands stable until it sees ack, then drops req (or presents a new request).
  - If req is still high in the IDLE cycle after ack, a new transaction starts.
  - Dropping req during ACCESS does not abort the access; it completes and acks.
- Request changes while busy are ignored; the losing requester waits, with no starvation (round-robin).
- A synchronous reset mid-ACCESS or mid-DONE aborts the transaction: strobes go to 0 at that edge and no ack is issued.
- There are never two cs signals asserted together, and never rd and wr asserted together.

Test Plan:
- Reset then single read: m0 read addr 0x0000_0010, mem_rdata = 0xDEAD_BEEF, ACC_CYC = 1 -> dm_cs = dm_rd = 1 for one cycle; m0_ack pulses 2 cycles after req with m0_rdata = 0xDEAD_BEEF; io_* stay 0.
- IO write: m1 write addr 0xFFFF_F004, data 0x0000_00AA -> io_cs = io_wr = 1, madr = 0xFFFF_F004, idp = 0x0000_00AA; m1_ack pulses; dm_* stay 0.
- Contention: m0 and m1 raise req in the same cycle after reset -> m0 is served first; m1 is served next (gnt 0 then 1); if both are held high, service alternates 0,1,0,1.
- ACC_CYC = 3 read -> rd strobe high for exactly 3 cycles; data is captured from the 3rd cycle; ack arrives 4 cycles after the req edge.
- Reset asserted during ACCESS of a write -> strobes go low at the next edge, no ack is issued, busy = 0; first post-reset tie goes to m0.
- m0 drops req mid-ACCESS -> access still completes and m0_ack pulses once; no second transaction follows.
